// File: rtl/irq_arbiter.sv
// irq_arbiter: prioritises ext/sw/timer machine interrupts and hands one registered
// request plus mcause to the trap sequencer, blocking nesting until mret.
module irq_arbiter #(
    parameter int N_EXT       = 4,
    parameter int EXT_EDGE    = 1,
    parameter int SYNC_STAGES = 2,
    localparam int IW         = $clog2(N_EXT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             timer_irq_i,
    input  logic             sw_irq_i,
    input  logic [N_EXT-1:0] ext_irq_i,
    input  logic [31:0]      csr_mstatus_i,
    input  logic [31:0]      csr_mie_i,
    input  logic             excp_busy_i,
    input  logic             irq_ack_i,
    input  logic             mret_i,
    output logic             irq_req_o,
    output logic [31:0]      irq_cause_o,
    output logic [IW-1:0]    irq_ext_id_o,
    output logic [31:0]      mip_o,
    output logic [N_EXT-1:0] ext_pend_o
);
    localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
    localparam logic [31:0] CAUSE_SW  = 32'h8000_0003;
    localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;

    typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_t;
    state_t state, state_nx;

    logic [N_EXT-1:0] sync [SYNC_STAGES];
    logic [N_EXT-1:0] pend, clr;
    logic [31:0]      cand, cause_nx;
    logic [IW-1:0]    win_id;
    logic             ext_cause, src_ok, take;
    logic             unused_mstatus;

    assign unused_mstatus = ^{csr_mstatus_i[31:4], csr_mstatus_i[2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= '0;
        end else begin
            sync[0] <= ext_irq_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
        end
    end

    generate
        if (EXT_EDGE != 0) begin : g_edge
            logic [N_EXT-1:0] dly;
            // a fresh edge beats a same-cycle clear so no interrupt is dropped
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dly  <= '0;
                    pend <= '0;
                end else begin
                    dly  <= sync[SYNC_STAGES-1];
                    pend <= (pend & ~clr) | (sync[SYNC_STAGES-1] & ~dly);
                end
            end
        end else begin : g_level
            assign pend = sync[SYNC_STAGES-1];
        end
    endgenerate

    assign mip_o      = {20'b0, |pend, 3'b0, timer_irq_i, 3'b0, sw_irq_i, 3'b0};
    assign ext_pend_o = pend;
    assign cand       = mip_o & csr_mie_i & {32{csr_mstatus_i[3]}};
    assign irq_req_o  = state == REQ;

    always_comb begin
        win_id = '0;
        for (int i = N_EXT - 1; i >= 0; i--)
            if (pend[i]) win_id = IW'(i);
    end

    assign cause_nx  = cand[11] ? CAUSE_EXT : cand[3] ? CAUSE_SW : CAUSE_TMR;
    assign ext_cause = irq_cause_o == CAUSE_EXT;
    assign src_ok    = ext_cause ? cand[11] & pend[irq_ext_id_o] : cand[irq_cause_o[4:0]];

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? ((cand != '0 && !excp_busy_i) ? REQ : IDLE) :
                   state == REQ  ? (irq_ack_i ? HANDLER : src_ok ? REQ : IDLE) :
                                   (mret_i ? IDLE : HANDLER);
    end

    assign take = state == IDLE && state_nx == REQ;
    assign clr  = (state == REQ && irq_ack_i && ext_cause) ? N_EXT'(1) << irq_ext_id_o : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            irq_cause_o  <= '0;
            irq_ext_id_o <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                irq_cause_o  <= cause_nx;
                irq_ext_id_o <= cand[11] ? win_id : '0;
            end
        end
    end
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed scenarios plus random traffic, each cycle compared
// against a behavioural model of the interrupt arbiter.
module tb_irq_arbiter;
    localparam int N = 4;
    localparam int S = 2;
    localparam logic [31:0] C_EXT = 32'h8000_000B;
    localparam logic [31:0] C_SW  = 32'h8000_0003;
    localparam logic [31:0] C_TMR = 32'h8000_0007;

    logic        clk = 0, rst = 1;
    logic        timer = 0, sw = 0, busy = 0, ack = 0, mret = 0;
    logic [N-1:0] ext = '0;
    logic [31:0] mstatus = '0, mie = '0;
    logic        req;
    logic [31:0] cause, mip;
    logic [1:0]  ext_id;
    logic [N-1:0] pend;

    int n_chk = 0, n_pass = 0;

    // model: 0 idle, 1 request raised, 2 handler running
    int          m_mode = 0, m_id = 0;
    logic [31:0] m_cause = '0;
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] h[$];

    irq_arbiter #(.N_EXT(N), .EXT_EDGE(1), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .timer_irq_i(timer), .sw_irq_i(sw), .ext_irq_i(ext),
        .csr_mstatus_i(mstatus), .csr_mie_i(mie), .excp_busy_i(busy),
        .irq_ack_i(ack), .mret_i(mret), .irq_req_o(req), .irq_cause_o(cause),
        .irq_ext_id_o(ext_id), .mip_o(mip), .ext_pend_o(pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] m_mip();
        logic [31:0] r;
        r = '0;
        r[11] = m_pend != '0;
        r[7]  = timer;
        r[3]  = sw;
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_id = 0; m_cause = '0; m_pend = '0;
        h = {};
        repeat (S + 1) h.push_back('0);
    endtask

    // h holds the ext samples of the last S+1 edges, oldest first
    task automatic model_edge();
        logic [N-1:0] clr;
        logic ok, mie_on;
        int low;
        clr = '0;
        mie_on = mstatus[3];
        low = -1;
        for (int i = 0; i < N; i++) if (m_pend[i] && low < 0) low = i;
        if (m_mode == 0) begin
            if (!busy) begin
                if (mie_on && mie[11] && low >= 0) begin m_mode = 1; m_cause = C_EXT; m_id = low; end
                else if (mie_on && mie[3] && sw) begin m_mode = 1; m_cause = C_SW; m_id = 0; end
                else if (mie_on && mie[7] && timer) begin m_mode = 1; m_cause = C_TMR; m_id = 0; end
            end
        end else if (m_mode == 1) begin
            if (m_cause == C_EXT) ok = mie_on && mie[11] && m_pend[m_id];
            else if (m_cause == C_SW) ok = mie_on && mie[3] && sw;
            else ok = mie_on && mie[7] && timer;
            if (ack) begin
                m_mode = 2;
                if (m_cause == C_EXT) clr[m_id] = 1'b1;
            end else if (!ok) m_mode = 0;
        end else if (mret) m_mode = 0;
        m_pend = (m_pend & ~clr) | (h[1] & ~h[0]);
        h.push_back(ext);
        void'(h.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("req", {31'b0, req}, {31'b0, m_mode == 1});
        chk("cause", cause, m_cause);
        chk("ext_id", {30'b0, ext_id}, m_id);
        chk("mip", mip, m_mip());
        chk("pend", {28'b0, pend}, {28'b0, m_pend});
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, req}, 0);
        chk("rst_cause", cause, 0);
        chk("rst_mip", mip, 0);
        rst = 0;
        // timer
        mstatus = 32'h8; mie = 32'h80; timer = 1;
        tick();
        chk("tmr_req", {31'b0, req}, 1);
        chk("tmr_cause", cause, C_TMR);
        ack = 1; tick(); ack = 0;
        chk("tmr_ack", {31'b0, req}, 0);
        timer = 0; mret = 1; tick(); mret = 0; tick();
        chk("tmr_idle", {31'b0, req}, 0);
        // priority
        mstatus = 0; mie = 32'h888; sw = 1; timer = 1; ext = 4'b0100;
        repeat (4) tick();
        mstatus = 32'h8; tick();
        chk("pri_req", {31'b0, req}, 1);
        chk("pri_cause", cause, C_EXT);
        chk("pri_id", {30'b0, ext_id}, 2);
        ack = 1; tick(); ack = 0; ext = 0;
        mret = 1; tick(); mret = 0;
        chk("pri_ret", {31'b0, req}, 0);
        tick();
        chk("pri_sw", cause, C_SW);
        ack = 1; tick(); ack = 0; sw = 0; timer = 0;
        mret = 1; tick(); mret = 0;
        // withdrawal
        timer = 1; mie = 32'h80; tick();
        chk("wd_req", {31'b0, req}, 1);
        mstatus = 0; tick();
        chk("wd_drop", {31'b0, req}, 0);
        chk("wd_cause", cause, C_TMR);
        mstatus = 32'h8; tick();
        chk("wd_again", {31'b0, req}, 1);
        ack = 1; tick(); ack = 0; timer = 0;
        mret = 1; tick(); mret = 0;
        // edge pending
        mie = 0; ext = 4'b0010; tick(); ext = 0; tick(); tick();
        chk("edge_set", {28'b0, pend}, 4'b0010);
        tick(); tick();
        chk("edge_held", {28'b0, pend}, 4'b0010);
        chk("edge_mask", {31'b0, req}, 0);
        mie = 32'h800; tick();
        chk("edge_req", {31'b0, req}, 1);
        chk("edge_id", {30'b0, ext_id}, 1);
        ack = 1; tick(); ack = 0;
        chk("edge_clr", {28'b0, pend}, 0);
        mret = 1; tick(); mret = 0;
        ext = 4'b0010; tick(); ext = 0; tick(); tick(); tick();
        chk("edge_req2", {31'b0, req}, 1);
        ext = 4'b0010; tick(); ext = 0; tick();
        ack = 1; tick(); ack = 0;
        chk("edge_wins", {28'b0, pend}, 4'b0010);
        // busy and nesting
        mie = 0; mret = 1; tick(); mret = 0;
        busy = 1; timer = 1; mie = 32'h80;
        repeat (3) tick();
        chk("busy_block", {31'b0, req}, 0);
        busy = 0; tick();
        chk("busy_rel", {31'b0, req}, 1);
        ack = 1; tick(); ack = 0;
        repeat (3) tick();
        chk("hnd_block", {31'b0, req}, 0);
        mret = 1; tick(); mret = 0;
        chk("hnd_ret", {31'b0, req}, 0);
        tick();
        chk("hnd_req", {31'b0, req}, 1);
        // async reset in REQ with a pending edge
        timer = 0;
        #3 rst = 1;
        #1;
        chk("ar_req", {31'b0, req}, 0);
        chk("ar_cause", cause, 0);
        chk("ar_id", {30'b0, ext_id}, 0);
        chk("ar_mip", mip, 0);
        chk("ar_pend", {28'b0, pend}, 0);
        model_reset();
        @(posedge clk); #1 rst = 0;
        // random traffic
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) ext[b] = ~ext[b];
            timer   = $urandom_range(3) == 0;
            sw      = $urandom_range(4) == 0;
            mstatus = ($urandom_range(5) != 0) ? 32'h8 : 32'h0;
            mie     = $urandom & 32'h888;
            busy    = $urandom_range(3) == 0;
            ack     = $urandom_range(2) == 0;
            mret    = $urandom_range(3) == 0;
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
